// File: rtl/alu_issue_stage.sv
// Decode/issue stage: turns an RV32I instruction into the ALU operand bundle
// (op, alu_a, alu_b) and holds it in a single-entry valid/ready register.
`ifndef ALUOP_ADD
`define ALUOP_ADD     4'd0
`define ALUOP_SUB     4'd1
`define ALUOP_SLL     4'd2
`define ALUOP_LT      4'd3
`define ALUOP_LTU     4'd4
`define ALUOP_XOR     4'd5
`define ALUOP_SRL     4'd6
`define ALUOP_SRA     4'd7
`define ALUOP_OR      4'd8
`define ALUOP_AND     4'd9
`define ALUOP_B       4'd10
`define ALUOP_A_ADD_4 4'd11
`endif

module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [XLEN-1:0]  out_alu_a,
    output logic [XLEN-1:0]  out_alu_b,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic [2:0]       out_funct3,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j, shamt;
    logic [3:0]      d_op;
    logic [XLEN-1:0] d_a, d_b;
    logic            d_we, d_ill;
    logic            load;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rd     = inst[11:7];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    // Immediate shifts carry only the shift amount; funct7 bits must not leak into b.
    assign shamt = XLEN'(inst[24:20]);

    always_comb begin
        d_op  = `ALUOP_ADD;
        d_a   = '0;
        d_b   = '0;
        d_we  = 1'b0;
        d_ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                d_a  = rs1_data;
                d_b  = rs2_data;
                d_we = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_op = `ALUOP_ADD;
                        3'b001:  d_op = `ALUOP_SLL;
                        3'b010:  d_op = `ALUOP_LT;
                        3'b011:  d_op = `ALUOP_LTU;
                        3'b100:  d_op = `ALUOP_XOR;
                        3'b101:  d_op = `ALUOP_SRL;
                        3'b110:  d_op = `ALUOP_OR;
                        default: d_op = `ALUOP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_op = `ALUOP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_op = `ALUOP_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            7'b0010011: begin
                d_a  = rs1_data;
                d_b  = imm_i;
                d_we = 1'b1;
                case (f3)
                    3'b000: d_op = `ALUOP_ADD;
                    3'b010: d_op = `ALUOP_LT;
                    3'b011: d_op = `ALUOP_LTU;
                    3'b100: d_op = `ALUOP_XOR;
                    3'b110: d_op = `ALUOP_OR;
                    3'b111: d_op = `ALUOP_AND;
                    3'b001: begin
                        d_op  = `ALUOP_SLL;
                        d_b   = shamt;
                        d_ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        d_b = shamt;
                        if (f7 == 7'b0000000)      d_op = `ALUOP_SRL;
                        else if (f7 == 7'b0100000) d_op = `ALUOP_SRA;
                        else                       d_ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                d_op = `ALUOP_B;
                d_b  = imm_u;
                d_we = 1'b1;
            end
            7'b0010111: begin
                d_a  = pc;
                d_b  = imm_u;
                d_we = 1'b1;
            end
            7'b1101111: begin
                d_op = `ALUOP_A_ADD_4;
                d_a  = pc;
                d_b  = imm_j;
                d_we = 1'b1;
            end
            7'b1100111: begin
                d_op  = `ALUOP_A_ADD_4;
                d_a   = pc;
                d_b   = imm_i;
                d_we  = 1'b1;
                d_ill = (f3 != 3'b000);
            end
            7'b1100011: begin
                d_a = rs1_data;
                d_b = rs2_data;
                case (f3)
                    3'b000, 3'b001: d_op = `ALUOP_SUB;
                    3'b100, 3'b101: d_op = `ALUOP_LT;
                    3'b110, 3'b111: d_op = `ALUOP_LTU;
                    default:        d_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                d_a  = rs1_data;
                d_b  = imm_i;
                d_we = 1'b1;
            end
            7'b0100011: begin
                d_a = rs1_data;
                d_b = imm_s;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_op = `ALUOP_ADD;
            d_a  = '0;
            d_b  = '0;
            d_we = 1'b0;
        end
        if (rd == 5'd0) d_we = 1'b0;
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_op        <= `ALUOP_ADD;
            out_alu_a     <= '0;
            out_alu_b     <= '0;
            out_rd        <= '0;
            out_rd_we     <= 1'b0;
            out_funct3    <= '0;
            out_illegal   <= 1'b0;
            illegal_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_op      <= d_op;
            out_alu_a   <= d_a;
            out_alu_b   <= d_b;
            out_rd      <= rd;
            out_rd_we   <= d_we;
            out_funct3  <= f3;
            out_illegal <= d_ill;
            if (d_ill && illegal_count != {CNT_W{1'b1}})
                illegal_count <= illegal_count + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions with hand-computed bundles.
module tb_alu_issue_stage;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_LTU = 4'd4,
                           OP_SRA = 4'd7, OP_B = 4'd10, OP_AADD4 = 4'd11;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  f3;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, out_rd_we, out_illegal;
    logic [31:0] inst = 0, pc = 0, rs1_data = 0, rs2_data = 0, out_alu_a, out_alu_b;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [15:0] illegal_count;

    int   tests = 0, fails = 0;
    bit   bulk = 0;
    exp_t sb[$];

    alu_issue_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_funct3(out_funct3), .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd, input logic we,
                                input logic [2:0] f3, input logic ill, input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.op = op; e.a = a; e.b = b; e.rd = rd;
        e.we = we; e.f3 = f3; e.ill = ill; e.cnt = cnt;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !bulk) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bundle: op=%0d a=%h b=%h with empty scoreboard",
                         out_op, out_alu_a, out_alu_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (out_op !== e.op || out_alu_a !== e.a || out_alu_b !== e.b ||
                    out_rd !== e.rd || out_rd_we !== e.we || out_funct3 !== e.f3 ||
                    out_illegal !== e.ill || illegal_count !== e.cnt) begin
                    fails++;
                    $display("FAIL %s: got op=%0d a=%h b=%h rd=%0d we=%b f3=%0d ill=%b cnt=%0d, expected op=%0d a=%h b=%h rd=%0d we=%b f3=%0d ill=%b cnt=%0d",
                             e.name, out_op, out_alu_a, out_alu_b, out_rd, out_rd_we, out_funct3,
                             out_illegal, illegal_count, e.op, e.a, e.b, e.rd, e.we, e.f3, e.ill, e.cnt);
                end
            end
        end
    end

    // Drive one instruction; returns right after the edge on which it was accepted.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input bit push, input exp_t e);
        bit ok;
        int n;
        inst = i; pc = p; rs1_data = r1; rs2_data = r2; in_valid = 1;
        if (push) sb.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                check({"accept_timeout_", e.name}, 64'(ok), 64'd1);
                break;
            end
        end
        in_valid = 0;
    endtask

    exp_t dummy;

    initial begin
        dummy = mk("none", 0, 0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1;
        @(posedge clk); #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        send(32'hFFD08293, 0, 10, 0, 1, mk("addi", OP_ADD, 10, 32'hFFFFFFFD, 5, 1, 0, 0, 0));
        @(posedge clk); #1;

        out_ready = 0;
        send(32'h402081B3, 0, 100, 30, 1, mk("sub", OP_SUB, 100, 30, 3, 1, 0, 0, 0));
        fork
            send(32'h4040D213, 0, 100, 30, 1, mk("srai", OP_SRA, 100, 4, 4, 1, 5, 0, 0));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {out_valid, in_ready, out_op, out_alu_a, out_alu_b[15:0], out_rd},
                                        {1'b1, 1'b0, OP_SUB, 32'd100, 16'd30, 5'd3});
                    @(posedge clk); #1;
                end
                out_ready = 1;
            end
        join
        @(posedge clk); #1;

        send(32'h008000EF, 32'h100, 0, 0, 1, mk("jal", OP_AADD4, 32'h100, 8, 1, 1, 0, 0, 0));
        send(32'h0020E063, 0, 7, 9, 1, mk("bltu", OP_LTU, 7, 9, 0, 0, 6, 0, 0));
        send(32'h123453B7, 0, 1, 2, 1, mk("lui", OP_B, 0, 32'h12345000, 7, 1, 5, 0, 0));
        send(32'hFE20AE23, 0, 32'h40, 3, 1, mk("sw", OP_ADD, 32'h40, 32'hFFFFFFFC, 28, 0, 2, 0, 0));
        send(32'h00001117, 32'h200, 0, 0, 1, mk("auipc", OP_ADD, 32'h200, 32'h1000, 2, 1, 1, 0, 0));
        send(32'hFFFFFFFF, 0, 5, 6, 1, mk("ill_ones", OP_ADD, 0, 0, 31, 0, 7, 1, 1));
        send(32'h022082B3, 0, 5, 6, 1, mk("ill_mul", OP_ADD, 0, 0, 5, 0, 0, 1, 2));

        flush = 1;
        send(32'hFFFFFFFF, 0, 5, 6, 0, dummy);
        flush = 0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_count", 64'(illegal_count), 64'd2);

        send(32'h00002063, 0, 5, 6, 1, mk("ill_br010", OP_ADD, 0, 0, 0, 0, 2, 1, 3));
        send(32'h00208033, 0, 5, 6, 1, mk("add_x0", OP_ADD, 5, 6, 0, 0, 0, 0, 3));
        @(posedge clk); #1;

        out_ready = 0;
        send(32'hFFD08293, 0, 10, 0, 0, dummy);
        @(posedge clk); #2;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 0;
        #1;
        sb.delete();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bundle", {out_op, out_alu_a, out_alu_b}, {OP_ADD, 32'd0, 32'd0});
        check("rst_fields", {out_rd, out_rd_we, out_funct3, out_illegal}, 64'd0);
        check("rst_count", 64'(illegal_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        out_ready = 1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        bulk = 1;
        inst = 32'hFFFFFFFF; in_valid = 1;
        repeat (65535) @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        @(posedge clk); #1;
        bulk = 0;
        check("count_at_max", 64'(illegal_count), 64'hFFFF);
        send(32'hFFFFFFFF, 0, 0, 0, 1, mk("ill_saturate", OP_ADD, 0, 0, 31, 0, 7, 1, 16'hFFFF));
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
